// File: rtl/if_id_queue_if.sv
// Fetch->decode queue interface. The master modport is the side that drives
// fetch data and decode ready; the slave modport is the queue itself.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [XLEN-1:0]            in_pc;
    logic [XLEN-1:0]            in_next_pc;
    logic [XLEN-1:0]            in_instr;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_pc;
    logic [XLEN-1:0]            out_next_pc;
    logic [XLEN-1:0]            out_instr;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output flush, in_valid, in_pc, in_next_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_next_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_next_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_next_pc, out_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, next_pc, instr} with a
// synchronous flush. Define IF_ID_QUEUE_BYPASS_EN for an empty-queue in->out bypass.
module if_id_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  q
);
    localparam int unsigned   AW  = $clog2(DEPTH);
    localparam int unsigned   CW  = AW + 1;
    localparam int unsigned   EW  = 3 * XLEN;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_full;
    logic           w_empty;
    logic           w_bypass;
    logic           w_push;
    logic           w_pop;
    logic [EW-1:0]  w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & q.in_valid & ~q.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry consumed by decode in the same cycle is never stored.
    assign w_push = q.in_valid & ~w_full & ~q.flush & ~(w_bypass & q.out_ready);
    assign w_pop  = ~w_empty & q.out_ready & ~q.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (q.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {q.in_pc, q.in_next_pc, q.in_instr};
    end

    always_comb begin
        q.in_ready    = ~w_full;
        q.count       = r_count;
        q.out_valid   = 1'b0;
        q.out_pc      = '0;
        q.out_next_pc = '0;
        q.out_instr   = NOP;
        if (w_bypass) begin
            q.out_valid   = 1'b1;
            q.out_pc      = q.in_pc;
            q.out_next_pc = q.in_next_pc;
            q.out_instr   = q.in_instr;
        end else if (!w_empty) begin
            q.out_valid   = 1'b1;
            q.out_pc      = w_head[EW-1 -: XLEN];
            q.out_next_pc = w_head[2*XLEN-1 -: XLEN];
            q.out_instr   = w_head[XLEN-1:0];
        end
    end
endmodule
